// File: rtl/wb_data_ram_pkg.sv
// Shared definitions for the Wishbone data RAM: reset levels, bus widths,
// FSM state encoding and the request address check.
package wb_data_ram_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_ADDR_WIDTH = 32;
  localparam int SEL_WIDTH      = BUS_DATA_WIDTH / 8;

  typedef logic [BUS_DATA_WIDTH-1:0] data_t;
  typedef logic [BUS_ADDR_WIDTH-1:0] addr_t;
  typedef logic [SEL_WIDTH-1:0]      sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // A request is bad when it is not word aligned or falls past the array.
  function automatic logic is_bad_addr(input addr_t adr, input int unsigned addr_width);
    return (adr[1:0] != 2'b00) || ((adr >> (addr_width + 2)) != '0);
  endfunction

endpackage

// File: rtl/wb_data_ram_if.sv
// Wishbone classic slave bus bundle for wb_data_ram; signal names follow the
// slave's point of view (_i driven by the master, _o driven by the slave).
interface wb_data_ram_if;
  import wb_data_ram_pkg::*;

  logic  wb_cyc_i;
  logic  wb_stb_i;
  logic  wb_we_i;
  addr_t wb_adr_i;
  sel_t  wb_sel_i;
  data_t wb_dat_i;
  data_t wb_dat_o;
  logic  wb_ack_o;
  logic  wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_data_ram_array.sv
// Word-addressed storage with one byte-lane write port and a synchronous,
// registered read port whose output register is cleared by reset.
module wb_data_ram_array
  import wb_data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  sel_t                  sel,
  input  data_t                 wdata,
  output data_t                 rdata
);

  data_t mem [0:(2**ADDR_WIDTH)-1];

  // NOTE: the storage array has no reset; only the read register does, so
  // contents survive rst and the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone classic data RAM slave: request latch, address checks, wait-state
// FSM and registered ack/err pulses around a wb_data_ram_array.
module wb_data_ram
  import wb_data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  wb_data_ram_if.slave     bus
);

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [2:0] WAIT_LOAD = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

  state_e                state;
  logic [2:0]            wait_cnt;
  logic                  ack_q;
  logic                  err_q;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  sel_t                  sel_q;
  data_t                 dat_q;

  logic                  req;
  logic                  bad;
  logic                  go_ack;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_adr;
  sel_t                  cur_sel;
  data_t                 cur_dat;

  assign req = bus.wb_cyc_i & bus.wb_stb_i;
  assign bad = is_bad_addr(bus.wb_adr_i, ADDR_WIDTH);

  // With no wait states the commit edge is the accept edge, so the array is
  // fed straight from the bus in IDLE and from the latch otherwise.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    cur_we  = we_q;
    cur_adr = adr_q;
    cur_sel = sel_q;
    cur_dat = dat_q;
    go_ack  = 1'b0;
    if (state == ST_IDLE) begin
      cur_we  = bus.wb_we_i;
      cur_adr = bus.wb_adr_i[ADDR_WIDTH+1:2];
      cur_sel = bus.wb_sel_i;
      cur_dat = bus.wb_dat_i;
      go_ack  = req && !bad && NO_WAIT;
    end else if (state == ST_WAIT) begin
      go_ack  = bus.wb_cyc_i && (wait_cnt == 3'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            we_q  <= bus.wb_we_i;
            adr_q <= bus.wb_adr_i[ADDR_WIDTH+1:2];
            sel_q <= bus.wb_sel_i;
            dat_q <= bus.wb_dat_i;
            if (bad) begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end else if (!NO_WAIT) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.wb_cyc_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt == 3'd0) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_ACK, ST_ERR: state <= ST_IDLE;
        default:        state <= ST_IDLE;
      endcase
    end
  end

  wb_data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (go_ack & cur_we),
    .rd_en (go_ack & ~cur_we),
    .addr  (cur_adr),
    .sel   (cur_sel),
    .wdata (cur_dat),
    .rdata (bus.wb_dat_o)
  );

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;

endmodule

// File: doc/wb_data_ram.md
WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width (1024 x 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before ack, legal range 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port wb_cyc_i  input  1  bus cycle active.
REQ-006 SHALL have port wb_stb_i  input  1  strobe, this slave selected.
REQ-007 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port wb_adr_i  input  32  byte address.
REQ-009 SHALL have port wb_sel_i  input  4  byte-lane enables; bit n = bits 8n+7:8n.
REQ-010 SHALL have port wb_dat_i  input  32  write data.
REQ-011 SHALL have port wb_dat_o  output  32  read data, registered.
REQ-012 SHALL have port wb_ack_o  output  1  normal termination, one-cycle pulse.
REQ-013 SHALL have port wb_err_o  output  1  error termination, one-cycle pulse.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK, ERR.
REQ-015 IDLE: on a rising edge with wb_cyc_i & wb_stb_i, SHALL latch we, adr, sel and dat_i, then go to ERR if the request is bad, else to WAIT if WAIT_STATES > 0, else to ACK.
REQ-016 A request SHALL be bad if wb_adr_i[1:0] != 0, or if wb_adr_i[31:ADDR_WIDTH+2] != 0.
REQ-017 WAIT SHALL count WAIT_STATES cycles with a 3-bit counter, then go to ACK; wb_cyc_i low while in WAIT SHALL abort to IDLE with no write, no ack and wb_dat_o unchanged.
REQ-018 ACK SHALL assert wb_ack_o for exactly one cycle, then return to IDLE.
REQ-019 ERR SHALL assert wb_err_o for exactly one cycle, then return to IDLE; the memory and wb_dat_o SHALL be unchanged.
REQ-020 Latency: wb_ack_o/wb_err_o SHALL be high in the cycle after edge N+WAIT_STATES, where N is the edge that accepted the request; ERR SHALL always take 1 cycle.
REQ-021 A write SHALL commit only the lanes with a set sel bit, on the edge entering ACK; sel = 0000 SHALL still ack and write nothing.
REQ-022 A read SHALL load wb_dat_o on the edge entering ACK.
REQ-023 wb_dat_o SHALL hold its value outside ACK; in a read ACK cycle the unselected lanes SHALL still carry the memory contents.
REQ-024 wb_ack_o and wb_err_o SHALL never be high together.
REQ-025 wb_ack_o and wb_err_o SHALL be low in IDLE and WAIT.
REQ-026 If wb_cyc_i & wb_stb_i is still high in the IDLE cycle after ACK or ERR, it SHALL be taken as a new request; the minimum back-to-back spacing is WAIT_STATES+2 cycles.
REQ-027 Request inputs SHALL be ignored outside IDLE, except for the wb_cyc_i abort in WAIT.

Reset
REQ-028 rst high SHALL immediately force state IDLE, wait counter 0, wb_ack_o 0, wb_err_o 0 and wb_dat_o 32'h0, independent of clk.
REQ-029 Reset in WAIT or ACK SHALL cancel the transaction, with no write if the commit edge has not yet occurred.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 The first request SHALL be accepted on the first rising edge after rst falls.

Structure
REQ-032 The shared defines file SHALL hold the RstEnable/RstDisable levels, the bus data and address widths, the sel width and the FSM state encodings.
REQ-033 The storage array SHALL be a sub-module, wb_data_ram_array: 2**ADDR_WIDTH x 32 bits, one write port with 4 byte-lane enables, synchronous read.
REQ-034 wb_data_ram SHALL hold the FSM, the latch registers and the address checks.

Verification
REQ-035 Reset: rst high 195 ns, then write adr 0x10, sel 1111, data 0xDEADBEEF, then read adr 0x10 -> with WAIT_STATES=1, ack 2 cycles after acceptance; read data 0xDEADBEEF.
REQ-036 Byte lanes: after REQ-035, write adr 0x10, sel 0101, data 0x11223344 -> read returns 0xDE22BE44.
REQ-037 Errors: write adr 0x12 -> wb_err_o for one cycle, no ack; write adr 0x1000 with ADDR_WIDTH=10 -> wb_err_o; a following read of 0x10 is unchanged.
REQ-038 Abort: with WAIT_STATES=3, drop wb_cyc_i in the 2nd WAIT cycle of a write of 0xCAFEF00D to 0x20 -> no ack and no err; a read of 0x20 returns its old value.
REQ-039 Back-to-back and reset: hold cyc/stb high over 3 reads -> acks spaced WAIT_STATES+2 cycles apart; assert rst during WAIT of a write -> ack and err stay 0, wb_dat_o goes to 0 asynchronously, target word unchanged.
